mem_ctrl: RTL
=============

# mem_ctrl

Memory access controller between the CPU control unit and the RAM. Takes one read or write request at a time, sequences the RAM's MAR/enable/rnw/bus handshake, and waits for MFC. Returns read data with a one-cycle done pulse. A watchdog aborts accesses whose MFC never arrives and flags an error.

## Interface
Parameters:
- AW, 8: address width (matches RAM MAR)
- DW, 8: data width (matches RAM MBR/bus)
- TIMEOUT, 15: max cycles spent in ACCESS+RELEASE before abort

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- req  in  1  access request, sampled only in IDLE; held by requester until busy rises
- wr  in  1  1 = write, 0 = read; sampled with req
- addr  in  AW  target address; sampled with req
- wdata  in  DW  write data; sampled with req
- busy  out  1  high from accept edge until return to IDLE
- done  out  1  one-cycle pulse at completion or abort
- rdata  out  DW  last read data; held until next successful read
- err  out  1  sticky timeout flag; cleared when next request accepted
- mem_mar  out  AW  RAM address
- mem_enable  out  1  RAM enable
- mem_rnw  out  1  RAM read(1)/write(0)
- mem_bus  out  DW  RAM write data
- mem_mfc  in  1  RAM memory-function-complete
- mem_mbr  in  DW  RAM read data

## Operation
- FSM states: IDLE, SETUP, ACCESS, RELEASE.
- IDLE: on req=1, latch addr/wdata/wr into holding regs and drive mem_mar/mem_bus/mem_rnw from them. Set busy=1, clear err and the watchdog, go SETUP. mem_enable stays 0.
- SETUP: one cycle so address and rnw are stable before the enable edge. Set mem_enable=1, go ACCESS.
- ACCESS: if mem_mfc=1 at the edge: a read loads rdata←mem_mbr; a write leaves rdata unchanged. Then mem_enable←0, go RELEASE. Entering ACCESS guarantees at least one rising CLK edge with enable=1 and rnw=0, which is the RAM write edge.
- RELEASE: wait for mem_mfc=0. Then done←1 for one cycle, busy←0, go IDLE.
- Watchdog: counts every cycle in ACCESS/RELEASE. When the count reaches TIMEOUT: mem_enable←0, err←1, done pulse, busy←0, go IDLE. rdata is not updated on abort.
- mem_mar/mem_rnw/mem_bus hold their values after the access until the next accept.
- req while busy is ignored; nothing is queued.
- Reset values: busy, done, err, mem_enable = 0; rdata, mem_mar, mem_bus = 0; mem_rnw = 1; state IDLE; watchdog 0.
- RST_N low mid-access drops mem_enable immediately (asynchronous), discards the access, and produces no done pulse.

## Timing
- Accept edge E0. SETUP→ACCESS at E1, with mem_enable high after E1. MFC seen at E2, rdata valid and enable low after E2. MFC low seen at E3. done high for the cycle after E3.
- Nominal latency: req accepted → done = 4 edges. Earliest next accept is E4, which may coincide with the done-high cycle.
- mem_enable high for exactly one CLK edge when the RAM responds in zero wait.
- A slow MFC extends ACCESS 1 cycle per wait. Abort happens at the TIMEOUT-th counted edge.
- mem_mfc is treated as a same-domain signal with no synchronizer.

## Structure
- Package mem_ctrl_pkg holds the state enum (IDLE, SETUP, ACCESS, RELEASE) and the default TIMEOUT constant.
- Single module with no sub-modules. The watchdog is an inline counter of width $clog2(TIMEOUT+1).

## Test plan
- Reset: hold RST_N=0 with random inputs → busy=done=err=mem_enable=0, mem_rnw=1, rdata=0x00.
- Read: RAM address 0x00 holds 0x48; req, wr=0, addr=0x00 → mem_enable high for 1 edge, done 4 edges after accept, rdata=0x48, err=0.
- Write then read: write 0xA5 to 0x20, then read 0x20 → write shows mem_rnw=0 with mem_enable=1 at exactly one edge; read returns rdata=0xA5.
- Timeout: RAM model holds MFC at 0, TIMEOUT=15 → err=1, done pulse 15 edges after entering ACCESS, mem_enable=0, rdata unchanged. Next accepted req clears err.
- Busy collision: a second req (addr 0x01) while busy → ignored, only the first access occurs. After done, re-asserting req starts a new access at E4.
- Reset mid-access: drop RST_N while in ACCESS → mem_enable falls without a clock edge, no done pulse, FSM back in IDLE after release.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and defaults for the memory access controller
package mem_ctrl_pkg;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Cycles allowed in ACCESS+RELEASE before the access is abandoned
    localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - single-request RAM access sequencer with MFC watchdog
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          req,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic [AW-1:0] mem_mar,
    output logic          mem_enable,
    output logic          mem_rnw,
    output logic [DW-1:0] mem_bus,
    input  logic          mem_mfc,
    input  logic [DW-1:0] mem_mbr
);

    // Watchdog holds 0..TIMEOUT-1; the edge seen with the last value is the TIMEOUT-th counted edge
    localparam int              WDW     = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);

    state_t         state;
    logic [WDW-1:0] wdog;

    // Sequencer: accept, setup, enable until MFC, wait MFC release, with watchdog abort
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            wdog       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
            mem_mar    <= '0;
            mem_bus    <= '0;
            mem_rnw    <= 1'b1;
            mem_enable <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        mem_mar <= addr;
                        mem_bus <= wdata;
                        mem_rnw <= ~wr;
                        busy    <= 1'b1;
                        err     <= 1'b0;
                        wdog    <= '0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    // Address and rnw have been stable for a full cycle before enable rises
                    mem_enable <= 1'b1;
                    state      <= ACCESS;
                end
                ACCESS: begin
                    if (wdog == WD_LAST) begin
                        mem_enable <= 1'b0;
                        err        <= 1'b1;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                        if (mem_mfc) begin
                            if (mem_rnw) begin
                                rdata <= mem_mbr;
                            end
                            mem_enable <= 1'b0;
                            state      <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (wdog == WD_LAST) begin
                        mem_enable <= 1'b0;
                        err        <= 1'b1;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                        if (!mem_mfc) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
